rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8.sv | 131 +++++++++++++
 tb/tb_rr_arbiter8.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant and a rotating priority pointer.
// Define ARB_TIMEOUT_EN to force-release a grant after MAX_HOLD visible cycles and pulse timeout.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] grant_idx_q, grant_idx_d;
    logic       grant_valid_q, grant_valid_d;
    logic       timeout_q, timeout_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       expired;
    logic       release_c;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_arbiter8: MAX_HOLD must be in 1..255");
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;

    // hold_q counts edges already survived by the current grant; visible cycles = hold_q + 1
    assign expired = (state_q == GRANT) && (hold_q >= HOLD_LAST);

    always_comb begin
        hold_d = 8'd0;
        if (state_q == GRANT && !release_c)
            hold_d = hold_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= 8'd0;
        else        hold_q <= hold_d;
    end
`else
    assign expired = 1'b0;
`endif

    // Scan from ptr+7 down to ptr so the lowest rotated offset is written last and wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr_q + 3'(k);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign release_c = !en || !req[grant_idx_q] || expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= 3'd0;
            grant_q       <= 8'd0;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE:  if (en && win_found) state_d = GRANT;
            GRANT: if (release_c) begin
                state_d = IDLE;
                ptr_d   = grant_idx_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d       = 8'd0;
        grant_idx_d   = 3'd0;
        grant_valid_d = 1'b0;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: if (en && win_found) begin
                grant_d       = 8'd1 << win_idx;
                grant_idx_d   = win_idx;
                grant_valid_d = 1'b1;
            end
            GRANT: if (!release_c) begin
                grant_d       = grant_q;
                grant_idx_d   = grant_idx_q;
                grant_valid_d = 1'b1;
            end else begin
                // only a release caused purely by the hold limit is reported as a timeout
                timeout_d = expired && en && req[grant_idx_q];
            end
            default: ;
        endcase
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: pointer rotation, enable gating, async reset, hold/timeout.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic et);
        tests++;
        assert (grant === eg) else begin
            fails++;
            $error("FAIL %s grant: observed %h expected %h", tag, grant, eg);
        end
        tests++;
        assert (grant_idx === ei) else begin
            fails++;
            $error("FAIL %s grant_idx: observed %0d expected %0d", tag, grant_idx, ei);
        end
        tests++;
        assert (grant_valid === ev) else begin
            fails++;
            $error("FAIL %s grant_valid: observed %b expected %b", tag, grant_valid, ev);
        end
        tests++;
        assert (timeout === et) else begin
            fails++;
            $error("FAIL %s timeout: observed %b expected %b", tag, timeout, et);
        end
    endtask

    initial begin
        logic [7:0] onehot;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        #12;
        chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        // two requesters, pointer at 0 picks 0, then 7 after an idle cycle
        req = 8'h81; en = 1'b1;
        tick(); chk("r81_first", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h80;
        tick(); chk("r81_release", 8'h00, 3'd0, 1'b0, 1'b0);
        tick(); chk("r81_second", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h00;
        tick(); chk("r80_release", 8'h00, 3'd0, 1'b0, 1'b0);
        tick(); chk("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

        // full rotation with wrap 7 -> 0; others requesting during a grant are ignored
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            onehot = 8'h01 << (k % 8);
            tick(); chk("rot_grant", onehot, 3'(k % 8), 1'b1, 1'b0);
            tick(); chk("rot_hold1", onehot, 3'(k % 8), 1'b1, 1'b0);
            tick(); chk("rot_hold2", onehot, 3'(k % 8), 1'b1, 1'b0);
            req = 8'hFF & ~onehot;
            tick(); chk("rot_gap", 8'h00, 3'd0, 1'b0, 1'b0);
            req = 8'hFF;
        end
        req = 8'h00;
        tick(); chk("rot_done", 8'h00, 3'd0, 1'b0, 1'b0);

        // enable gating; en=0 mid-grant releases and moves ptr to 5
        en = 1'b0; req = 8'h10;
        tick(); chk("en0_a", 8'h00, 3'd0, 1'b0, 1'b0);
        tick(); chk("en0_b", 8'h00, 3'd0, 1'b0, 1'b0);
        en = 1'b1;
        tick(); chk("en1_grant", 8'h10, 3'd4, 1'b1, 1'b0);
        tick(); chk("en1_hold", 8'h10, 3'd4, 1'b1, 1'b0);
        en = 1'b0;
        tick(); chk("en0_release", 8'h00, 3'd0, 1'b0, 1'b0);
        en = 1'b1; req = 8'h21;
        tick(); chk("ptr5_pick", 8'h20, 3'd5, 1'b1, 1'b0);
        req = 8'h00;
        tick(); chk("ptr5_release", 8'h00, 3'd0, 1'b0, 1'b0);

        // async reset mid-grant; afterwards ptr=0 so 3 beats 7
        req = 8'h08;
        tick(); chk("pre_rst_grant", 8'h08, 3'd3, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1; req = 8'h88;
        tick(); chk("post_rst_ptr0", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h00;
        tick(); chk("post_rst_release", 8'h00, 3'd0, 1'b0, 1'b0);

        // constant request: timeout release or indefinite hold
        req = 8'h04;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            tick(); chk("to_visible", 8'h04, 3'd2, 1'b1, 1'b0);
        end
        tick(); chk("to_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
        tick(); chk("to_regrant", 8'h04, 3'd2, 1'b1, 1'b0);
        tick(); chk("to_pulse_once", 8'h04, 3'd2, 1'b1, 1'b0);
`else
        for (int c = 0; c < 100; c++) begin
            tick(); chk("hold_forever", 8'h04, 3'd2, 1'b1, 1'b0);
        end
`endif
        req = 8'h00;
        tick(); chk("final_release", 8'h00, 3'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
